// File: rtl/led_stream_sink_pkg.sv
// led_stream_sink_pkg: shared LED word field positions and handshake state encoding
package led_stream_sink_pkg;
  localparam int LED_COUNT  = 16;
  localparam int BRIGHT_LSB = 16;
  localparam int BRIGHT_MSB = 19;
  localparam int RSVD_LSB   = 20;
  typedef enum logic {ACCEPT, HOLD} state_t;
endpackage

// File: rtl/led_stream_sink_if.sv
// led_stream_sink_if: strobe/acknowledge LED word stream between producer and sink
interface led_stream_sink_if;
  logic [31:0] input_leds;
  logic        input_leds_stb;
  logic        input_leds_ack;
  modport master (output input_leds, output input_leds_stb, input input_leds_ack);
  modport slave  (input input_leds, input input_leds_stb, output input_leds_ack);
endinterface

// File: rtl/led_pwm.sv
// led_pwm: free-running PWM counter gating the latched pattern onto registered LED outputs
module led_pwm #(
  parameter int PWM_BITS  = 4,
  parameter int LED_COUNT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LED_COUNT-1:0] pattern,
  input  logic [PWM_BITS-1:0]  bright,
  output logic [LED_COUNT-1:0] leds
);
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                on;
  // all-ones brightness bypasses the compare so it means full duty, not (2^N-1)/2^N
  assign on = (&bright) || (pwm_cnt < bright);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pwm_cnt <= '0;
      leds    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      leds    <= on ? pattern : '0;
    end
endmodule

// File: rtl/led_stream_sink.sv
// led_stream_sink: accepts LED words over a strobe/ack stream and displays each for HOLD_CYCLES
module led_stream_sink
  import led_stream_sink_pkg::*;
#(
  parameter logic [31:0] HOLD_CYCLES = 32'd5000000,
  parameter int          PWM_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  led_stream_sink_if.slave     s,
  output logic [LED_COUNT-1:0] leds,
  output logic                 exception
);
  state_t                state;
  logic [31:0]           hold_cnt;
  logic [LED_COUNT-1:0]  pattern_reg;
  logic [PWM_BITS-1:0]   bright_reg;
  logic                  xfer;
  assign xfer = (state == ACCEPT) && s.input_leds_ack && s.input_leds_stb;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state            <= ACCEPT;
      s.input_leds_ack <= 1'b0;
      hold_cnt         <= '0;
      pattern_reg      <= '0;
      bright_reg       <= '1;
      exception        <= 1'b0;
    end else if (state == HOLD) begin
      if (hold_cnt == 32'd0) begin
        state            <= ACCEPT;
        s.input_leds_ack <= 1'b1;
      end else
        hold_cnt <= hold_cnt - 32'd1;
    end else if (xfer) begin
      state            <= HOLD;
      s.input_leds_ack <= 1'b0;
      hold_cnt         <= HOLD_CYCLES - 32'd1;
      pattern_reg      <= s.input_leds[LED_COUNT-1:0];
      bright_reg       <= PWM_BITS'(s.input_leds[BRIGHT_MSB:BRIGHT_LSB]);
      exception        <= exception | (|s.input_leds[31:RSVD_LSB]);
    end else
      s.input_leds_ack <= 1'b1;
  led_pwm #(.PWM_BITS(PWM_BITS), .LED_COUNT(LED_COUNT)) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .pattern (pattern_reg),
    .bright  (bright_reg),
    .leds    (leds)
  );
endmodule

// File: tb/tb_led_stream_sink.sv
// tb_led_stream_sink: directed and table-driven checks of the LED stream sink
module tb_led_stream_sink;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] leds;
  logic        exception;
  int          n_cmp = 0;
  int          n_fail = 0;
  led_stream_sink_if bus();
  led_stream_sink #(.HOLD_CYCLES(32'd8), .PWM_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (bus.slave),
    .leds      (leds),
    .exception (exception)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] word;
    logic [15:0] pat;
    int          on;
  } vec_t;
  vec_t vecs[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_ack();
    int k = 0;
    while (bus.input_leds_ack !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ack_wait_bound", 32'(k < 40), 32'd1);
  endtask
  // leaves the bench at the falling edge right after the transfer edge
  task automatic xfer(input logic [31:0] w);
    bus.input_leds     = w;
    bus.input_leds_stb = 1'b1;
    wait_ack();
    @(negedge clk);
    bus.input_leds_stb = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int low;
    int on_cnt;
    int bad;
    logic [15:0] lv;
    vecs[0] = '{32'h0004_FFFF, 16'hFFFF, 4};
    vecs[1] = '{32'h0000_FFFF, 16'hFFFF, 0};
    vecs[2] = '{32'h000F_FFFF, 16'hFFFF, 16};
    vecs[3] = '{32'h0008_00F0, 16'h00F0, 8};
    vecs[4] = '{32'h0001_0F0F, 16'h0F0F, 1};
    bus.input_leds     = 32'h000F_AAAA;
    bus.input_leds_stb = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ack", 32'(bus.input_leds_ack), 32'd0);
    chk("reset_leds", 32'(leds), 32'd0);
    chk("reset_exception", 32'(exception), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ack_first_edge", 32'(bus.input_leds_ack), 32'd1);
    chk("no_xfer_first_edge", 32'(leds), 32'd0);
    @(negedge clk);
    chk("ack_drops_after_xfer", 32'(bus.input_leds_ack), 32'd0);
    @(negedge clk);
    bus.input_leds_stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("first_word_leds", 32'(leds), 32'h0000_AAAA);
    end
    wait_ack();
    bus.input_leds     = 32'h000F_0001;
    bus.input_leds_stb = 1'b1;
    @(negedge clk);
    chk("b2b_first_xfer", 32'(bus.input_leds_ack), 32'd0);
    bus.input_leds = 32'h000F_0002;
    @(negedge clk);
    chk("b2b_first_leds", 32'(leds), 32'h0000_0001);
    low = 2;
    lv  = leds;
    while (bus.input_leds_ack !== 1'b1 && low < 40) begin
      @(negedge clk);
      if (bus.input_leds_ack !== 1'b1) begin
        low++;
        lv = leds;
      end
    end
    chk("b2b_ack_low_cycles", 32'(low), 32'd8);
    chk("hold_ignores_input", 32'(lv), 32'h0000_0001);
    @(negedge clk);
    chk("b2b_second_xfer", 32'(bus.input_leds_ack), 32'd0);
    bus.input_leds_stb = 1'b0;
    @(negedge clk);
    chk("b2b_second_leds", 32'(leds), 32'h0000_0002);
    foreach (vecs[v]) begin
      xfer(vecs[v].word);
      @(negedge clk);
      on_cnt = 0;
      bad    = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (leds === vecs[v].pat) on_cnt++;
        else if (leds !== 16'h0) bad++;
      end
      chk($sformatf("duty_on_%0d", v), 32'(on_cnt), 32'(vecs[v].on));
      chk($sformatf("duty_glitch_%0d", v), 32'(bad), 32'd0);
    end
    chk("exception_clean", 32'(exception), 32'd0);
    xfer(32'h0010_0000);
    chk("exception_set", 32'(exception), 32'd1);
    @(negedge clk);
    chk("rsvd_word_displayed", 32'(leds), 32'd0);
    xfer(32'h000F_1234);
    @(negedge clk);
    chk("exception_sticky", 32'(exception), 32'd1);
    chk("valid_after_exception", 32'(leds), 32'h0000_1234);
    xfer(32'h000F_5555);
    repeat (2) @(negedge clk);
    chk("pre_reset_leds", 32'(leds), 32'h0000_5555);
    chk("pre_reset_exception", 32'(exception), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_leds", 32'(leds), 32'd0);
    chk("async_reset_ack", 32'(bus.input_leds_ack), 32'd0);
    chk("async_reset_exception", 32'(exception), 32'd0);
    @(negedge clk);
    chk("reset_held_ack", 32'(bus.input_leds_ack), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ack_after_release", 32'(bus.input_leds_ack), 32'd1);
    chk("leds_after_release", 32'(leds), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/led_stream_sink.md
LED_STREAM_SINK -- requirements
Module: led_stream_sink

Interface
REQ-001 Parameter HOLD_CYCLES, default 5000000, sets the minimum cycles each accepted LED word is displayed (legal range 1..2^32-1).
REQ-002 Parameter PWM_BITS, default 4, sets the brightness-field width and the PWM counter width.
REQ-003 Port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, reset, asynchronous, active-low.
REQ-005 Port input_leds, input, 32, LED word: [15:0] LED pattern, [19:16] brightness, [31:20] reserved (must be zero).
REQ-006 Port input_leds_stb, input, 1, producer strobe; input_leds is valid while high.
REQ-007 Port input_leds_ack, output, 1, consumer acknowledge; a transfer occurs on any rising edge with stb and ack both high.
REQ-008 Port leds, output, 16, PWM-gated physical LED drive, active-high.
REQ-009 Port exception, output, 1, sticky flag for a protocol or data error.

Function
REQ-010 The block SHALL have two states, ACCEPT and HOLD.
REQ-011 In ACCEPT, input_leds_ack SHALL be 1, driven from a register and not combinationally from stb.
REQ-012 On a transfer in ACCEPT:
  - latch input_leds[15:0] into pattern_reg and input_leds[19:16] into bright_reg;
  - load the hold counter with HOLD_CYCLES-1;
  - move to HOLD, with ack 0 from the next cycle.
REQ-013 In HOLD, ack SHALL be 0 and the counter SHALL decrement each cycle.
REQ-014 In HOLD with counter 0, the block SHALL return to ACCEPT, so ack is low for exactly HOLD_CYCLES cycles after each transfer.
REQ-015 Stb high while ack is low SHALL be ignored; input_leds may change freely and is not sampled.
REQ-016 Stb may be held high across consecutive words; each ACCEPT cycle with stb high SHALL consume exactly one word.
REQ-017 A free-running PWM_BITS-bit counter pwm_cnt SHALL increment every cycle and wrap from all-ones to 0.
REQ-018 leds[i] SHALL equal pattern_reg[i] AND (bright_reg == all-ones OR pwm_cnt < bright_reg), registered (one-cycle latency).
REQ-019 Brightness 0 SHALL blank all LEDs; all-ones SHALL give 100% duty; value b otherwise SHALL give b/2^PWM_BITS duty.
REQ-020 A new pattern SHALL reach leds 2 cycles after its transfer edge (latch, then output register).
REQ-021 exception SHALL set on a transfer whose bits [31:20] are nonzero; the word is still displayed.
REQ-022 exception SHALL clear only on reset.

Reset
REQ-023 While rst=0, the block SHALL force:
  - state ACCEPT, input_leds_ack 0;
  - pattern_reg 0, bright_reg all-ones;
  - leds 0, hold counter 0, pwm_cnt 0, exception 0.
REQ-024 input_leds_ack SHALL rise on the first clock edge after rst deasserts; no transfer can occur on that edge.
REQ-025 Reset asserted in HOLD SHALL abort the hold immediately, without waiting for a clock edge.

Structure
REQ-026 A shared package SHALL hold the constants LED_COUNT=16, BRIGHT_LSB=16, BRIGHT_MSB=19 and RSVD_LSB=20, plus the ACCEPT/HOLD state enumeration.
REQ-027 The PWM counter and compare SHALL live in one sub-module, led_pwm, parameterised by PWM_BITS and LED_COUNT.
REQ-028 The handshake FSM and hold counter SHALL remain in led_stream_sink.

Verification (bench uses HOLD_CYCLES=8, PWM_BITS=4)
REQ-029 Reset release, stb held high with word 0x000F_AAAA:
  - ack high on the first edge after reset;
  - transfer on the next edge;
  - leds=0xAAAA constantly, 2 cycles later.
REQ-030 Back-to-back words 0x000F_0001 then 0x000F_0002 with stb held high:
  - ack low for exactly 8 cycles between the two transfers;
  - leds change 0x0001 -> 0x0002.
REQ-031 Word 0x0004_FFFF:
  - leds=0xFFFF for exactly 4 of every 16 cycles, else 0;
  - word 0x0000_FFFF keeps leds=0 continuously.
REQ-032 Word 0x0010_0000 (reserved bit set) -> exception=1 next cycle and stays 1 across later valid words until reset.
REQ-033 rst pulsed low in HOLD, 3 cycles after a transfer:
  - leds=0, ack=0 and exception=0 immediately;
  - ack=1 one edge after release.
